pwm_bank: RTL and testbench

Parametrised multi-channel PWM generator, successor to the fixed 16-channel onboarding PWM peripheral. It takes byte-wide register writes from the SPI peripheral and drives NUM_CH outputs. The outputs share a prescaled timebase with a programmable period. Duty, period and prescaler values are double-buffered so that updates take effect only at a period boundary, unless immediate mode is selected. It sits between `spi_peripheral` and the `{uio_out, uo_out}` pins of the top level.

---
 rtl/pwm_bank_pkg.sv | 50 +++++
 rtl/pwm_timebase.sv | 49 ++++
 rtl/pwm_bank.sv | 162 ++++++++++++++++
 tb/tb_pwm_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg
// Shared definitions for the multi-channel PWM bank: bus widths, the
// register map, the control-register bit layout and the address decoder
// used by the register file.
package pwm_bank_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] EN_OUT_BASE = 7'h00;
    localparam logic [ADDR_W-1:0] EN_PWM_BASE = 7'h04;
    localparam logic [ADDR_W-1:0] PRESC_ADDR  = 7'h08;
    localparam logic [ADDR_W-1:0] PERIOD_ADDR = 7'h09;
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = 7'h0A;
    localparam logic [ADDR_W-1:0] DUTY_BASE   = 7'h20;

    localparam int IMM_BIT = 0;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_EN_OUT,
        REG_EN_PWM,
        REG_PRESC,
        REG_PERIOD,
        REG_CTRL,
        REG_DUTY
    } reg_sel_e;

    // Everything from DUTY_BASE upwards is the duty window; whether the
    // channel actually exists is decided by the register file.
    function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
        reg_sel_e sel;
        sel = REG_NONE;
        if (addr >= DUTY_BASE) begin
            sel = REG_DUTY;
        end else if (addr[ADDR_W-1:2] == EN_OUT_BASE[ADDR_W-1:2]) begin
            sel = REG_EN_OUT;
        end else if (addr[ADDR_W-1:2] == EN_PWM_BASE[ADDR_W-1:2]) begin
            sel = REG_EN_PWM;
        end else if (addr == PRESC_ADDR) begin
            sel = REG_PRESC;
        end else if (addr == PERIOD_ADDR) begin
            sel = REG_PERIOD;
        end else if (addr == CTRL_ADDR) begin
            sel = REG_CTRL;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase
// Shared prescaled timebase for the PWM bank.
//   clk, rst    : system clock, synchronous active-high reset
//   presc_act   : active prescaler value, prescaler counts 0..presc_act
//   period_act  : active period value, cnt counts 0..period_act
//   cnt         : current PWM counter
//   tick        : prescaler terminal count this cycle
//   wrap        : tick on the last count of the period
module pwm_timebase #(
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] presc_act,
    input  logic [CNT_W-1:0]   period_act,
    output logic [CNT_W-1:0]   cnt,
    output logic               tick,
    output logic               wrap
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Only equality is tested, so a counter left above a freshly shrunk
    // limit (immediate mode) runs up to all-ones and wraps to 0 naturally.
    always_comb begin
        tick    = (presc_q == presc_act);
        wrap    = tick && (cnt_q == period_act);
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == period_act) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank
// Parametrised multi-channel PWM generator with double-buffered duty,
// period and prescaler registers written over a byte-wide bus.
//   clk, rst     : system clock, synchronous active-high reset
//   wr_en        : single-cycle write strobe
//   wr_addr      : register address
//   wr_data      : write data
//   pwm_out      : registered channel outputs
//   period_start : registered one-cycle pulse aligned with the first
//                  pwm_out cycle of each new period
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam int NUM_BYTES = NUM_CH / 8;

    logic [NUM_CH-1:0]  en_out_q, en_out_d;
    logic [NUM_CH-1:0]  en_pwm_q, en_pwm_d;
    logic               imm_mode_q, imm_mode_d;
    logic [PRESC_W-1:0] presc_sh_q, presc_sh_d, presc_act_q, presc_act_d;
    logic [CNT_W-1:0]   period_sh_q, period_sh_d, period_act_q, period_act_d;
    logic               wrap_q, wrap_d;
    logic               period_start_q, period_start_d;
    logic [NUM_CH-1:0]  pwm_out_q, pwm_out_d;

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic               wrap;
    logic               load_act;
    reg_sel_e           reg_sel;
    logic [ADDR_W-1:0]  duty_idx;
    logic               duty_wr;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .presc_act  (presc_act_q),
        .period_act (period_act_q),
        .cnt        (cnt),
        .tick       (tick),
        .wrap       (wrap)
    );

    assign reg_sel  = decode_addr(wr_addr);
    assign duty_idx = wr_addr - DUTY_BASE;
    assign duty_wr  = wr_en && (reg_sel == REG_DUTY);

    // Shadows copy from their registered value, so a write landing on the
    // wrap cycle misses this copy and waits for the next one.
    assign load_act = imm_mode_q || wrap;

    always_comb begin
        en_out_d    = en_out_q;
        en_pwm_d    = en_pwm_q;
        imm_mode_d  = imm_mode_q;
        presc_sh_d  = presc_sh_q;
        period_sh_d = period_sh_q;

        if (wr_en) begin
            case (reg_sel)
                REG_EN_OUT: begin
                    for (int k = 0; k < NUM_BYTES; k++) begin
                        if (int'(wr_addr[1:0]) == k) begin
                            en_out_d[8*k +: 8] = wr_data;
                        end
                    end
                end
                REG_EN_PWM: begin
                    for (int k = 0; k < NUM_BYTES; k++) begin
                        if (int'(wr_addr[1:0]) == k) begin
                            en_pwm_d[8*k +: 8] = wr_data;
                        end
                    end
                end
                REG_PRESC:  presc_sh_d  = wr_data[PRESC_W-1:0];
                REG_PERIOD: period_sh_d = wr_data[CNT_W-1:0];
                REG_CTRL:   imm_mode_d  = wr_data[IMM_BIT];
                default:    ;
            endcase
        end

        presc_act_d  = load_act ? presc_sh_q  : presc_act_q;
        period_act_d = load_act ? period_sh_q : period_act_q;

        // wrap is already tick-qualified; the explicit guard keeps the
        // period_start pipeline tied to an actual timebase step.
        wrap_d         = tick && wrap;
        period_start_d = wrap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out_q       <= '0;
            en_pwm_q       <= '0;
            imm_mode_q     <= 1'b0;
            presc_sh_q     <= '0;
            presc_act_q    <= '0;
            period_sh_q    <= '1;
            period_act_q   <= '1;
            wrap_q         <= 1'b0;
            period_start_q <= 1'b0;
            pwm_out_q      <= '0;
        end else begin
            en_out_q       <= en_out_d;
            en_pwm_q       <= en_pwm_d;
            imm_mode_q     <= imm_mode_d;
            presc_sh_q     <= presc_sh_d;
            presc_act_q    <= presc_act_d;
            period_sh_q    <= period_sh_d;
            period_act_q   <= period_act_d;
            wrap_q         <= wrap_d;
            period_start_q <= period_start_d;
            pwm_out_q      <= pwm_out_d;
        end
    end

    // Per-channel duty shadow/active pair and compare. Duty addresses whose
    // index is NUM_CH or above match no channel and are dropped.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
        logic [CNT_W-1:0] duty_act_q, duty_act_d;

        always_comb begin
            duty_sh_d = duty_sh_q;
            if (duty_wr && (duty_idx == ADDR_W'(c))) begin
                duty_sh_d = wr_data[CNT_W-1:0];
            end
            duty_act_d = load_act ? duty_sh_q : duty_act_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_sh_q  <= '0;
                duty_act_q <= '0;
            end else begin
                duty_sh_q  <= duty_sh_d;
                duty_act_q <= duty_act_d;
            end
        end

        assign pwm_out_d[c] = en_out_q[c] & (~en_pwm_q[c] | (cnt < duty_act_q));
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank
// Directed bench for pwm_bank: a 16-channel / 8-bit instance covers the
// main behaviour and an 8-channel / 4-bit instance covers the narrow build.
module tb_pwm_bank;
    import pwm_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_en8;
    logic [6:0]  wr_addr, wr_addr8;
    logic [7:0]  wr_data, wr_data8;
    logic [15:0] pwm16;
    logic        ps16;
    logic [7:0]  pwm8;
    logic        ps8;

    int vectors     = 0;
    int miscompares = 0;
    bit useSmall    = 1'b0;
    int periodLen;
    int firstLow;
    int highs[4];

    always #5 clk = ~clk;

    pwm_bank #(.NUM_CH(16), .CNT_W(8), .PRESC_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pwm_out      (pwm16),
        .period_start (ps16)
    );

    pwm_bank #(.NUM_CH(8), .CNT_W(4), .PRESC_W(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en8),
        .wr_addr      (wr_addr8),
        .wr_data      (wr_data8),
        .pwm_out      (pwm8),
        .period_start (ps8)
    );

    function automatic logic [31:0] curPwm();
        return useSmall ? 32'(pwm8) : 32'(pwm16);
    endfunction

    function automatic logic curPs();
        return useSmall ? ps8 : ps16;
    endfunction

    // One clock, then settle 1 time unit so samples and drives sit away
    // from the active edge.
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] addr, input logic [7:0] data);
        if (useSmall) begin
            wr_en8   = 1'b1;
            wr_addr8 = addr;
            wr_data8 = data;
        end else begin
            wr_en    = 1'b1;
            wr_addr  = addr;
            wr_data  = data;
        end
        stepCycles(1);
        wr_en  = 1'b0;
        wr_en8 = 1'b0;
    endtask

    // Advance to the next period_start pulse (always moves at least one cycle).
    task automatic waitPeriodStart(input string tag, input int budget);
        int n;
        n = 0;
        stepCycles(1);
        while (curPs() !== 1'b1 && n < budget) begin
            stepCycles(1);
            n++;
        end
        checkOutput(tag, 32'(curPs()), 32'd1);
    endtask

    // Starting on a period_start cycle, record one whole period: its length,
    // high counts for channels 0..3 and the first low cycle of channel 0.
    // Returns positioned on the following period_start cycle.
    task automatic measurePeriod(input int budget);
        logic [31:0] p;
        periodLen = 0;
        firstLow  = -1;
        for (int ch = 0; ch < 4; ch++) highs[ch] = 0;
        do begin
            p = curPwm();
            for (int ch = 0; ch < 4; ch++) highs[ch] += int'(p[ch]);
            if (firstLow < 0 && p[0] == 1'b0) firstLow = periodLen;
            periodLen++;
            stepCycles(1);
        end while (curPs() !== 1'b1 && periodLen < budget);
    endtask

    initial begin
        int firstPs;
        int secondPs;
        int pwmHigh;
        int h;
        int n;

        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_en8   = 1'b0;
        wr_addr8 = '0;
        wr_data8 = '0;
        stepCycles(3);
        checkOutput("reset pwm_out", curPwm(), 32'd0);
        checkOutput("reset period_start", 32'(curPs()), 32'd0);

        // Defaults: period 256 cycles, outputs held low.
        rst      = 1'b0;
        firstPs  = -1;
        secondPs = -1;
        pwmHigh  = 0;
        stepCycles(1);
        for (int j = 0; j < 600; j++) begin
            if (curPwm() != 32'd0) pwmHigh++;
            if (curPs() === 1'b1) begin
                if (firstPs < 0) firstPs = j;
                else if (secondPs < 0) secondPs = j;
            end
            stepCycles(1);
        end
        checkOutput("default first period_start", firstPs, 256);
        checkOutput("default second period_start", secondPs, 512);
        checkOutput("default pwm_out low", pwmHigh, 0);

        // Basic duty 0x40 on channel 0.
        applyStimulus(DUTY_BASE, 8'h40);
        applyStimulus(EN_OUT_BASE, 8'h01);
        applyStimulus(EN_PWM_BASE, 8'h01);
        waitPeriodStart("basic sync", 600);
        measurePeriod(600);
        checkOutput("basic period length", periodLen, 256);
        checkOutput("basic ch0 high", highs[0], 64);
        checkOutput("basic ch0 first low", firstLow, 64);

        // Extremes: ch1 duty 0, ch2 duty 0xFF with period 0xFE.
        applyStimulus(DUTY_BASE + 7'd1, 8'h00);
        applyStimulus(DUTY_BASE + 7'd2, 8'hFF);
        applyStimulus(PERIOD_ADDR, 8'hFE);
        applyStimulus(EN_PWM_BASE, 8'h07);
        applyStimulus(EN_OUT_BASE, 8'h07);
        waitPeriodStart("extreme sync", 600);
        measurePeriod(600);
        checkOutput("period FE length", periodLen, 255);
        checkOutput("duty40 ch0 high", highs[0], 64);
        checkOutput("duty0 ch1 high", highs[1], 0);
        checkOutput("dutyFF ch2 high", highs[2], 255);
        checkOutput("disabled ch3 high", highs[3], 0);

        // Static high on ch3: visible two cycles after the write cycle.
        applyStimulus(EN_OUT_BASE, 8'h0F);
        checkOutput("static ch3 at N+1", 32'(curPwm() >> 3) & 32'd1, 32'd0);
        stepCycles(1);
        checkOutput("static ch3 at N+2", 32'(curPwm() >> 3) & 32'd1, 32'd1);

        // Prescaler 3, period 9, duty 5: 40-cycle period, 20 high.
        applyStimulus(PRESC_ADDR, 8'd3);
        applyStimulus(PERIOD_ADDR, 8'd9);
        applyStimulus(DUTY_BASE, 8'd5);
        waitPeriodStart("presc sync a", 600);
        waitPeriodStart("presc sync b", 600);
        measurePeriod(100);
        checkOutput("presc period length", periodLen, 40);
        checkOutput("presc ch0 high", highs[0], 20);
        checkOutput("presc ch0 first low", firstLow, 20);
        checkOutput("presc ch1 high", highs[1], 0);
        checkOutput("presc ch2 high", highs[2], 40);
        checkOutput("presc ch3 static", highs[3], 40);
        measurePeriod(100);
        checkOutput("period_start spacing", periodLen, 40);

        // Shadowed duty change mid-period (displayed cnt 6): old duty holds.
        stepCycles(24);
        applyStimulus(DUTY_BASE, 8'd8);
        h = 0;
        n = 0;
        while (curPs() !== 1'b1 && n < 100) begin
            h += int'(curPwm() & 32'd1);
            stepCycles(1);
            n++;
        end
        checkOutput("shadow hold high", h, 0);
        checkOutput("shadow remaining cycles", n, 15);
        measurePeriod(100);
        checkOutput("shadow applied high", highs[0], 32);

        // Immediate mode: duty 8 -> 2 while displayed cnt is 3.
        applyStimulus(CTRL_ADDR, 8'h01);
        stepCycles(11);
        applyStimulus(DUTY_BASE, 8'd2);
        checkOutput("imm old duty", curPwm() & 32'd1, 32'd1);
        stepCycles(2);
        checkOutput("imm new duty", curPwm() & 32'd1, 32'd0);
        applyStimulus(CTRL_ADDR, 8'h00);

        // Write on the exact wrap cycle is deferred one full period.
        waitPeriodStart("wrap sync", 100);
        stepCycles(38);
        applyStimulus(DUTY_BASE, 8'd6);
        stepCycles(1);
        checkOutput("wrap write period_start", 32'(curPs()), 32'd1);
        measurePeriod(100);
        checkOutput("wrap write deferred", highs[0], 8);
        measurePeriod(100);
        checkOutput("wrap write applied", highs[0], 24);

        // Reset mid-period at cnt 0x80.
        applyStimulus(PRESC_ADDR, 8'd0);
        applyStimulus(PERIOD_ADDR, 8'hFF);
        applyStimulus(DUTY_BASE, 8'hFF);
        waitPeriodStart("reset sync a", 700);
        waitPeriodStart("reset sync b", 700);
        stepCycles(127);
        checkOutput("pre-reset ch0", curPwm() & 32'd1, 32'd1);
        rst = 1'b1;
        stepCycles(1);
        checkOutput("mid reset pwm_out", curPwm(), 32'd0);
        checkOutput("mid reset period_start", 32'(curPs()), 32'd0);
        rst = 1'b0;
        stepCycles(4);
        checkOutput("post reset pwm_out", curPwm(), 32'd0);

        // Narrow build: duty 4 of 16, write to 0x28 must not alias ch0.
        useSmall = 1'b1;
        applyStimulus(DUTY_BASE, 8'h04);
        applyStimulus(DUTY_BASE + 7'd8, 8'h0F);
        applyStimulus(EN_OUT_BASE, 8'h01);
        applyStimulus(EN_PWM_BASE, 8'h01);
        waitPeriodStart("small sync a", 100);
        waitPeriodStart("small sync b", 100);
        measurePeriod(100);
        checkOutput("small period length", periodLen, 16);
        checkOutput("small ch0 high", highs[0], 4);
        checkOutput("small ch0 first low", firstLow, 4);
        checkOutput("small ch1 high", highs[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
